// File: rtl/traj_point_streamer_if.sv
// rtl/traj_point_streamer_if.sv - point/byte handshake bundle for traj_point_streamer
//
// Purpose: carries the point input channel from the trajectory core and the
// byte output channel to the host.
// Signals:
//   pt_valid, pt_x[7:0], pt_y[7:0], pt_last  core -> streamer sample
//   pt_ready                                 streamer -> core, FIFO not full
//   byte_out[7:0], byte_valid                streamer -> host serialized byte
//   byte_ack                                 host -> streamer, byte accepted
// Modports: slave = streamer side, master = core/host side.
interface traj_point_streamer_if;
  logic       pt_valid;
  logic [7:0] pt_x;
  logic [7:0] pt_y;
  logic       pt_last;
  logic       pt_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ack;

  modport slave (
    input  pt_valid, pt_x, pt_y, pt_last, byte_ack,
    output pt_ready, byte_out, byte_valid
  );

  modport master (
    output pt_valid, pt_x, pt_y, pt_last, byte_ack,
    input  pt_ready, byte_out, byte_valid
  );
endinterface

// File: rtl/traj_point_streamer.sv
// rtl/traj_point_streamer.sv - buffers (x, y) samples and serializes them as bytes
//
// Purpose: a DEPTH-entry FIFO of {last, y, x} samples drained by a small FSM
// that emits x then y per sample on an 8-bit valid/ack port. Completed frames
// (pt_last samples) are counted in frame_cnt.
// Optional feature: define TRAJ_STREAMER_CHECKSUM_EN to append an XOR checksum
// byte of all x/y bytes of the frame after the last sample's y byte.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         traj_point_streamer_if.slave (point input, byte output)
//   frame_cnt   completed frame count, wraps 255 -> 0
//   fifo_level  current FIFO occupancy, 0..DEPTH
module traj_point_streamer #(
  parameter int DEPTH   = 4,
  parameter int COORD_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  traj_point_streamer_if.slave      bus,
  output logic [7:0]                frame_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 * COORD_W + 1;

`ifdef TRAJ_STREAMER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y, SEND_CK} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y} state_e;
`endif

  state_e state_q, state_d;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;
  logic [7:0]         frame_cnt_q;
  logic               frame_inc;
  logic               push, pop, xfer, valid_int;
  logic [EW-1:0]      head;
  logic [COORD_W-1:0] head_x, head_y;
  logic               head_last;
  logic [7:0]         byte_out_d;

`ifdef TRAJ_STREAMER_CHECKSUM_EN
  logic [7:0]         ck_q, ck_d;
`endif

  // FIFO bookkeeping. pt_ready comes only from the registered level, so a
  // pop from a full FIFO frees the slot for the following cycle.
  assign bus.pt_ready = (level_q != LW'(DEPTH));
  assign push         = bus.pt_valid && bus.pt_ready;

  assign head      = mem_q[rd_ptr_q];
  assign head_x    = head[COORD_W-1:0];
  assign head_y    = head[2*COORD_W-1:COORD_W];
  assign head_last = head[EW-1];

  assign valid_int      = (state_q != IDLE);
  assign xfer           = valid_int && bus.byte_ack;
  // A sample leaves the FIFO once its y byte has been accepted.
  assign pop            = (state_q == SEND_Y) && xfer;

  assign bus.byte_valid = valid_int;
  assign bus.byte_out   = byte_out_d;
  assign frame_cnt      = frame_cnt_q;
  assign fifo_level     = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Sample storage has no reset: stale entries are never read because the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.pt_last, bus.pt_y, bus.pt_x};
    end
  end

  // Next-state, byte mux and checksum update.
  always_comb begin
    state_d    = state_q;
    byte_out_d = 8'h00;
    frame_inc  = 1'b0;
`ifdef TRAJ_STREAMER_CHECKSUM_EN
    ck_d       = ck_q;
`endif
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d = SEND_X;
        end
      end
      SEND_X: begin
        byte_out_d = head_x;
        if (xfer) begin
`ifdef TRAJ_STREAMER_CHECKSUM_EN
          ck_d = ck_q ^ head_x;
`endif
          state_d = SEND_Y;
        end
      end
      SEND_Y: begin
        byte_out_d = head_y;
        if (xfer) begin
`ifdef TRAJ_STREAMER_CHECKSUM_EN
          ck_d = ck_q ^ head_y;
          if (head_last) begin
            state_d = SEND_CK;
          end else if (level_d != '0) begin
            state_d = SEND_X;
          end else begin
            state_d = IDLE;
          end
`else
          frame_inc = head_last;
          // level_d already includes this pop and any same-cycle push, so a
          // sample arriving now is sent without a bubble.
          if (level_d != '0) begin
            state_d = SEND_X;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef TRAJ_STREAMER_CHECKSUM_EN
      SEND_CK: begin
        byte_out_d = ck_q;
        if (xfer) begin
          ck_d      = 8'h00;
          frame_inc = 1'b1;
          if (level_q != '0) begin
            state_d = SEND_X;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= 8'h00;
`ifdef TRAJ_STREAMER_CHECKSUM_EN
      ck_q        <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      // Pointers are exactly PW bits wide, so they wrap modulo DEPTH.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (frame_inc) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
`ifdef TRAJ_STREAMER_CHECKSUM_EN
      ck_q <= ck_d;
`endif
    end
  end

endmodule

// File: doc/traj_point_streamer.md
# traj_point_streamer

Downstream stage of the trajectory calculator core. Buffers (x, y) trajectory samples in a small FIFO and serializes each sample as two bytes onto the 8-bit output pins with a valid/ack handshake, so the external host can read points at its own pace. Frames are delimited by the core's `pt_last` flag. An optional XOR checksum byte closes each frame.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `COORD_W`, 8: coordinate width; fixed at 8 for byte serialization.

- `clk`  in  1  single clock; every flop is on its rising edge.
- `rst`  in  1  synchronous, active-high reset; the top level drives it as `~rst_n`.
- `pt_valid`  in  1  core presents a sample.
- `pt_x`  in  8  horizontal coordinate, unsigned.
- `pt_y`  in  8  vertical coordinate, unsigned.
- `pt_last`  in  1  sample is the final one of a trajectory frame.
- `pt_ready`  out  1  FIFO can accept a sample.
- `byte_out`  out  8  serialized byte.
- `byte_valid`  out  1  `byte_out` is valid.
- `byte_ack`  in  1  host accepts the byte, sampled high.
- `frame_cnt`  out  8  count of completed frames; wraps 255→0.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: `pt_valid && pt_ready` stores {last, y, x} at the write pointer.
- `pt_ready = (level != DEPTH)`. It is combinational from the registered level.
- When full, no push occurs in the same cycle as a pop. `pt_ready` rises the cycle after the pop.
- Transfer: `byte_valid && byte_ack` in the same cycle.
- While `byte_valid` is high and no ack arrives, `byte_out` holds stable.
- FSM states: IDLE, SEND_X, SEND_Y, SEND_CK.
  - IDLE → SEND_X when level != 0.
  - SEND_X → SEND_Y on transfer.
  - SEND_Y → on transfer, pop the FIFO, then:
    - SEND_CK if head.last and the macro is enabled;
    - else SEND_X if level after the pop != 0;
    - else IDLE.
  - SEND_CK → on transfer, go to SEND_X if level != 0, else IDLE.
- `byte_valid = (state != IDLE)`.
- `byte_out` by state:
  - SEND_X: head.x
  - SEND_Y: head.y
  - SEND_CK: checksum register
  - IDLE: 0x00
- `frame_cnt` increments on the transfer of a last sample's final byte. That byte is the Y byte, or the CK byte when the checksum is enabled.
- Pointers wrap modulo DEPTH. Level arithmetic uses width $clog2(DEPTH)+1, so no aliasing occurs at full.
- A simultaneous push and pop with level not full leaves the level unchanged.

## Timing
- Reset values:
  - state IDLE
  - `byte_valid` 0, `byte_out` 0x00
  - `pt_ready` 1, `fifo_level` 0, `frame_cnt` 0
  - checksum 0, both pointers 0
- FIFO contents are don't-care after reset.
- Latency: a push at edge N into an empty FIFO in IDLE gives `byte_valid`=1 with the x byte from cycle N+1, i.e. after edge N+1.
- Back-to-back: with `byte_ack` held high, one byte is transferred per cycle with no bubbles between samples while the FIFO is non-empty.
- `rst` mid-frame: at the next edge the FIFO empties, the FSM returns to IDLE, and the partial checksum is discarded. Nothing is emitted for the aborted frame.
- `byte_ack` while `byte_valid`=0 is ignored.

## Configuration
- `TRAJ_STREAMER_CHECKSUM_EN` defined:
  - An 8-bit checksum register XORs every transferred x and y byte.
  - After the last sample's y byte, SEND_CK emits the checksum.
  - The register clears to 0 when the CK byte transfers.
- Not defined:
  - SEND_CK and the checksum register are absent.
  - `pt_last` affects only `frame_cnt`.
  - The stream is pure x, y pairs.

## Test plan
- Single point x=0x12, y=0x34, last=1, ack held high:
  - bytes 0x12, 0x34, then 0x26 with the checksum enabled;
  - `frame_cnt`=1;
  - `byte_valid` rises exactly one cycle after the push edge.
- Backpressure: push 5 points with DEPTH=4 and ack low:
  - `pt_ready` drops after the 4th push and `fifo_level`=4;
  - ack one byte pair; `pt_ready` returns the next cycle;
  - the 5th point is accepted and order is preserved.
- Ack stalls: hold ack low for 7 cycles mid-X byte → `byte_out` is stable and nothing is lost or duplicated.
- Streaming: 3-point frame (0x01,0x02), (0x03,0x04), (0x05,0x06, last), ack always high:
  - 7 consecutive transfers ending in checksum 0x07;
  - 6 transfers when the macro is undefined.
- Reset mid-frame after the x byte: next cycle `byte_valid`=0 and level=0. A fresh frame then yields a correct checksum, unaffected by the discarded partial.
- Counter wrap: 256 single-point frames → `frame_cnt` returns to 0.
